// File: rtl/dmac_burst_ctrl.sv
// dmac_burst_ctrl: one DMA channel; reads a burst into the FIFO, then writes it out.
// Ports: clk, rst (sync, active-high), channel_en, cfg_burst_len, cfg_total,
//   HReady, HResp in; HTrans, HWrite, src_inc, dst_inc, fifo_wr, fifo_rd,
//   irq_done, irq_err, busy, beats_left out.
// Define DMAC_ERR_ABORT_EN to abort into ERROR on a bus error response.
module dmac_burst_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 16,
  localparam int BL_W     = $clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             channel_en,
  input  logic [BL_W-1:0]  cfg_burst_len,
  input  logic [CNT_W-1:0] cfg_total,
  input  logic             HReady,
  input  logic [1:0]       HResp,
  output logic [1:0]       HTrans,
  output logic             HWrite,
  output logic             src_inc,
  output logic             dst_inc,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic             irq_done,
  output logic             irq_err,
  output logic             busy,
  output logic [CNT_W-1:0] beats_left
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
`ifdef DMAC_ERR_ABORT_EN
    , S_ERROR = 3'd5
`endif
  } state_t;

  state_t state_q, state_d;
  state_t resume_q, resume_d;
  state_t tgt;

  logic [BL_W-1:0]  burst_q, burst_d;
  logic [BL_W-1:0]  n_q, n_d;
  logic [BL_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             first_q, first_d;
  logic             irq_done_q, irq_done_d;

  logic             in_beat;
  logic             err;
  logic             last;
  logic [BL_W-1:0]  cfg_bl;
  logic [CNT_W-1:0] left_nxt;

  function automatic logic [BL_W-1:0] clip(
    input logic [BL_W-1:0]  b,
    input logic [CNT_W-1:0] l
  );
    if (CNT_W'(b) > l) return l[BL_W-1:0];
    return b;
  endfunction

  assign in_beat = (state_q == S_READ) || (state_q == S_WRITE);

`ifdef DMAC_ERR_ABORT_EN
  assign err = in_beat && HReady && (HResp != 2'b00);
`else
  logic unused_hresp;
  assign unused_hresp = ^HResp;
  assign err = 1'b0;
`endif

  // Out-of-range burst lengths fall back to the largest burst.
  assign cfg_bl = (cfg_burst_len == '0 ||
                   cfg_burst_len > BL_W'(MAX_BURST)) ?
                  BL_W'(MAX_BURST) : cfg_burst_len;

  assign last     = (cnt_q == n_q - BL_W'(1));
  assign left_nxt = left_q - CNT_W'(n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      resume_q <= S_READ;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    tgt      = state_q;
    unique case (state_q)
      S_IDLE:
        if (channel_en)
          state_d = (cfg_total == '0) ? S_DONE : S_READ;
      S_READ, S_WRITE:
        if (HReady) begin
          if (state_q == S_READ)
            tgt = last ? S_WRITE : S_READ;
          else if (!last)
            tgt = S_WRITE;
          else
            tgt = (left_nxt == '0) ? S_DONE : S_READ;
          // Enable is only sampled once the current beat completes.
          if (tgt == S_DONE || channel_en) begin
            state_d = tgt;
          end else begin
            state_d  = S_HOLD;
            resume_d = tgt;
          end
`ifdef DMAC_ERR_ABORT_EN
          if (err) state_d = S_ERROR;
`endif
        end
      S_HOLD:
        if (channel_en) state_d = resume_q;
      S_DONE:
        if (!channel_en) state_d = S_IDLE;
`ifdef DMAC_ERR_ABORT_EN
      S_ERROR:
        if (!channel_en) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    first_d = first_q;
    if (state_q == S_IDLE && channel_en) begin
      burst_d = cfg_bl;
      left_d  = cfg_total;
      n_d     = clip(cfg_bl, cfg_total);
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (in_beat && HReady && !err) begin
      if (last) begin
        cnt_d   = '0;
        first_d = 1'b1;
        if (state_q == S_WRITE) begin
          left_d = left_nxt;
          n_d    = clip(burst_q, left_nxt);
        end
      end else begin
        cnt_d   = cnt_q + BL_W'(1);
        first_d = 1'b0;
      end
    end else if (state_q == S_HOLD && channel_en) begin
      first_d = 1'b1;
    end
    if (state_d == S_IDLE) left_d = '0;
  end

  assign irq_done_d = (state_d == S_DONE) && (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q    <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      left_q     <= '0;
      first_q    <= 1'b1;
      irq_done_q <= 1'b0;
    end else begin
      burst_q    <= burst_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      first_q    <= first_d;
      irq_done_q <= irq_done_d;
    end
  end

  always_comb begin
    HTrans     = 2'b00;
    HWrite     = 1'b0;
    src_inc    = 1'b0;
    dst_inc    = 1'b0;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    busy       = 1'b0;
    irq_err    = 1'b0;
    irq_done   = irq_done_q;
    beats_left = left_q;
    unique case (state_q)
      S_READ: begin
        HTrans  = first_q ? 2'b10 : 2'b11;
        fifo_wr = HReady && !err;
        src_inc = HReady && !err;
        busy    = 1'b1;
      end
      S_WRITE: begin
        HTrans  = first_q ? 2'b10 : 2'b11;
        HWrite  = 1'b1;
        fifo_rd = HReady && !err;
        dst_inc = HReady && !err;
        busy    = 1'b1;
      end
      S_HOLD: busy = 1'b1;
`ifdef DMAC_ERR_ABORT_EN
      S_ERROR: irq_err = 1'b1;
`endif
      default: ;
    endcase
    // Reset forces quiet outputs even before the state flop clears.
    if (rst) begin
      HTrans     = 2'b00;
      HWrite     = 1'b0;
      src_inc    = 1'b0;
      dst_inc    = 1'b0;
      fifo_wr    = 1'b0;
      fifo_rd    = 1'b0;
      busy       = 1'b0;
      irq_err    = 1'b0;
      irq_done   = 1'b0;
      beats_left = '0;
    end
  end

endmodule

// File: tb/tb_dmac_burst_ctrl.sv
// tb_dmac_burst_ctrl: randomized bench for dmac_burst_ctrl
// against a burst/beat-level transfer model.
module tb_dmac_burst_ctrl;
  localparam int CNT_W     = 16;
  localparam int MAX_BURST = 16;
  localparam int BL_W      = $clog2(MAX_BURST) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             channel_en;
  logic [BL_W-1:0]  cfg_burst_len;
  logic [CNT_W-1:0] cfg_total;
  logic             HReady;
  logic [1:0]       HResp;
  logic [1:0]       HTrans;
  logic             HWrite;
  logic             src_inc;
  logic             dst_inc;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             irq_done;
  logic             irq_err;
  logic             busy;
  logic [CNT_W-1:0] beats_left;

  int errs   = 0;
  int checks = 0;

  dmac_burst_ctrl #(.CNT_W(CNT_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .channel_en(channel_en),
    .cfg_burst_len(cfg_burst_len), .cfg_total(cfg_total),
    .HReady(HReady), .HResp(HResp), .HTrans(HTrans),
    .HWrite(HWrite), .src_inc(src_inc), .dst_inc(dst_inc),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .irq_done(irq_done), .irq_err(irq_err),
    .busy(busy), .beats_left(beats_left)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ov();
    return {HTrans, HWrite, src_inc, dst_inc,
            fifo_wr, fifo_rd, irq_done, irq_err, busy};
  endfunction

  function automatic logic [9:0] pk(
    input logic [1:0] tr, input logic wr,
    input logic si, input logic di,
    input logic fw, input logic fr,
    input logic dn, input logic er, input logic bz);
    return {tr, wr, si, di, fw, fr, dn, er, bz};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    cfg_total     = CNT_W'($urandom);
    cfg_burst_len = BL_W'($urandom);
`ifdef DMAC_ERR_ABORT_EN
    HResp = 2'b00;
`else
    HResp = 2'($urandom);
`endif
  endtask

  // One complete transfer: hold_at / stall_at index global beats
  // (reads and writes counted together), -1 disables them.
  task automatic run_xfer(input int total, input int bl,
                          input int hold_at, input int stall_at,
                          input int stall_pct);
    int b, left, n, g, st, nh;
    bit first, rdy, wr;
    logic [1:0] tr;
    b = (bl == 0 || bl > MAX_BURST) ? MAX_BURST : bl;
    cfg_total     = CNT_W'(total);
    cfg_burst_len = BL_W'(bl);
    channel_en    = 1'b1;
    HReady        = 1'($urandom);
    @(negedge clk);
    chk("idle_out", 32'(ov()), 32'(0));
    chk("idle_left", 32'(beats_left), 32'(0));
    nxt();
    left = total;
    g    = 0;
    while (left > 0) begin
      n = (b < left) ? b : left;
      for (int ph = 0; ph < 2; ph++) begin
        wr    = (ph == 1);
        first = 1'b1;
        for (int k = 0; k < n; k++) begin
          st = 0;
          do begin
            if (g == stall_at)
              rdy = (st >= 3);
            else
              rdy = (st >= 6) ||
                    (int'($urandom_range(99)) >= stall_pct);
            HReady = rdy;
            noise();
            if (g == hold_at) channel_en = 1'b0;
            tr = first ? 2'b10 : 2'b11;
            @(negedge clk);
            chk(wr ? "wr_beat" : "rd_beat", 32'(ov()),
                32'(pk(tr, wr, !wr && rdy, wr && rdy,
                       !wr && rdy, wr && rdy, 1'b0, 1'b0, 1'b1)));
            chk("beat_left", 32'(beats_left), 32'(left));
            nxt();
            st++;
          end while (!rdy);
          first = 1'b0;
          if (wr && k == n - 1) left -= n;
          if (g == hold_at) begin
            nh = 1 + int'($urandom_range(3));
            for (int h = 0; h <= nh; h++) begin
              HReady = 1'($urandom);
              noise();
              if (h == nh) channel_en = 1'b1;
              @(negedge clk);
              chk("hold_out", 32'(ov()),
                  32'(pk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1)));
              chk("hold_left", 32'(beats_left), 32'(left));
              nxt();
            end
            first = 1'b1;
          end
          g++;
        end
      end
    end
    HReady = 1'($urandom);
    noise();
    @(negedge clk);
    chk("done_irq", 32'(ov()),
        32'(pk(2'b00, 0, 0, 0, 0, 0, 1, 0, 0)));
    chk("done_left", 32'(beats_left), 32'(0));
    nxt();
    @(negedge clk);
    chk("done_stay", 32'(ov()), 32'(0));
    nxt();
    channel_en = 1'b0;
    @(negedge clk);
    chk("done_rel", 32'(ov()), 32'(0));
    nxt();
  endtask

  initial begin
    int total, bl, hold_at;
    rst           = 1'b1;
    channel_en    = 1'b0;
    cfg_total     = '0;
    cfg_burst_len = '0;
    HReady        = 1'b0;
    HResp         = 2'b00;
    #1;
    for (int i = 0; i < 3; i++) begin
      HReady     = 1'($urandom);
      channel_en = 1'($urandom);
      @(negedge clk);
      chk("rst_out", 32'(ov()), 32'(0));
      chk("rst_left", 32'(beats_left), 32'(0));
      nxt();
    end
    rst        = 1'b0;
    channel_en = 1'b0;
    nxt();

    run_xfer(8, 4, -1, -1, 0);
    run_xfer(10, 4, -1, -1, 0);
    run_xfer(4, 4, -1, 1, 0);
    run_xfer(8, 4, 5, -1, 0);
    run_xfer(0, 4, -1, -1, 0);
    run_xfer(20, 0, -1, -1, 10);
    run_xfer(20, 25, -1, -1, 10);
    run_xfer(3, 1, 2, -1, 30);

    for (int r = 0; r < 20; r++) begin
      total   = int'($urandom_range(40));
      bl      = int'($urandom_range(31));
      hold_at = -1;
      if (total > 0 && $urandom_range(1) == 1)
        hold_at = int'($urandom_range(2 * total - 2));
      run_xfer(total, bl, hold_at, -1,
               int'($urandom_range(40)));
    end

`ifdef DMAC_ERR_ABORT_EN
    cfg_total     = CNT_W'(8);
    cfg_burst_len = BL_W'(4);
    channel_en    = 1'b1;
    HReady        = 1'b1;
    HResp         = 2'b00;
    nxt();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("err_pre", 32'(ov()), 32'(pk(k == 0 ? 2'b10 : 2'b11,
          0, 1, 0, 1, 0, 0, 0, 1)));
      nxt();
    end
    HResp = 2'b01;
    @(negedge clk);
    chk("err_beat", 32'(ov()),
        32'(pk(2'b11, 0, 0, 0, 0, 0, 0, 0, 1)));
    nxt();
    HResp = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("err_hold", 32'(ov()),
          32'(pk(2'b00, 0, 0, 0, 0, 0, 0, 1, 0)));
      nxt();
    end
    channel_en = 1'b0;
    nxt();
    @(negedge clk);
    chk("err_idle", 32'(ov()), 32'(0));
    chk("err_left", 32'(beats_left), 32'(0));
    nxt();
`endif

    cfg_total     = CNT_W'(8);
    cfg_burst_len = BL_W'(4);
    channel_en    = 1'b1;
    HReady        = 1'b1;
    HResp         = 2'b00;
    nxt();
    repeat (5) nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", 32'(ov()), 32'(0));
    chk("rst_mid_left", 32'(beats_left), 32'(0));
    nxt();
    rst = 1'b0;
    run_xfer(0, 4, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmac_burst_ctrl.md
DMAC_BURST_CTRL -- requirements
Module: dmac_burst_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the total-beat counter.
REQ-002 SHALL have parameter MAX_BURST, default 16, largest burst in beats; BL_W = $clog2(MAX_BURST)+1.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port channel_en, input, 1, level enable; low pauses or releases the channel.
REQ-006 SHALL have port cfg_burst_len, input, BL_W, beats per burst, legal 1..MAX_BURST.
REQ-007 SHALL have port cfg_total, input, CNT_W, total beats to move.
REQ-008 SHALL have port HReady, input, 1, bus beat accepted.
REQ-009 SHALL have port HResp, input, 2, bus response; nonzero = error.
REQ-010 SHALL have port HTrans, output, 2, IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 SHALL have port HWrite, output, 1, high in write phase.
REQ-012 SHALL have ports src_inc and dst_inc, output, 1 each, advance source or destination address.
REQ-013 SHALL have ports fifo_wr and fifo_rd, output, 1 each, push read data or pop write data.
REQ-014 SHALL have ports irq_done and irq_err, output, 1 each; busy, output, 1; beats_left, output, CNT_W.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE, HOLD, DONE, ERROR.
REQ-016 IDLE with channel_en=1: SHALL latch cfg_burst_len and cfg_total, then go to READ, or to DONE if cfg_total=0.
REQ-017 Burst size n SHALL equal min(latched burst length, beats_left), computed at each READ entry.
REQ-018 READ/WRITE: HTrans SHALL be NONSEQ on the first beat of a burst and SEQ on later beats; HWrite=1 only in WRITE.
REQ-019 A beat SHALL complete only in a cycle with HReady=1; with HReady=0, all outputs SHALL hold and no counter SHALL move.
REQ-020 Completed READ beat: SHALL pulse fifo_wr and src_inc for that cycle.
REQ-021 Completed WRITE beat: SHALL pulse fifo_rd and dst_inc for that cycle.
REQ-022 After n READ beats: SHALL go to WRITE. After n WRITE beats: beats_left SHALL decrement by n, then go to DONE if the result is 0, else to READ.
REQ-023 channel_en low at a beat boundary: SHALL go to HOLD with HTrans=IDLE.
REQ-024 channel_en high in HOLD: SHALL return to the interrupted phase, resuming with NONSEQ.
REQ-025 channel_en low mid-beat (HReady=0): SHALL finish the beat before entering HOLD.
REQ-026 DONE entry: SHALL pulse irq_done for exactly one cycle.
REQ-027 DONE: SHALL stay until channel_en=0, then go to IDLE; no restart while enable is held high.
REQ-028 busy SHALL be high in READ, WRITE and HOLD.
REQ-029 beats_left SHALL be unsigned, never wrap below 0, and read 0 in IDLE.
REQ-030 cfg_burst_len=0 or >MAX_BURST SHALL be treated as MAX_BURST.
REQ-031 cfg inputs SHALL be ignored outside IDLE.

Reset
REQ-032 rst=1 SHALL force IDLE from any state, including mid-burst, on the next clock edge.
REQ-033 Under reset, every output SHALL be 0; HTrans SHALL be IDLE; beats_left SHALL be 0.

Configuration
REQ-034 Macro DMAC_ERR_ABORT_EN defined: HResp≠0 with HReady=1 in READ/WRITE SHALL abort to ERROR with HTrans=IDLE, irq_err held high until channel_en=0, then IDLE.
REQ-035 Macro DMAC_ERR_ABORT_EN undefined: HResp SHALL be ignored, irq_err SHALL be tied 0, and the ERROR state SHALL be absent.

Verification
REQ-036 cfg_total=8, cfg_burst_len=4, HReady=1: SHALL produce 4 fifo_wr, 4 fifo_rd, 4 fifo_wr, 4 fifo_rd; NONSEQ on beats 1 and 5 of each phase; one irq_done.
REQ-037 cfg_total=10, cfg_burst_len=4: SHALL produce bursts of 4, 4, 2; beats_left SHALL step 10→6→2→0.
REQ-038 HReady low 3 cycles on READ beat 2: HTrans/src_inc SHALL be held, 4 fifo_wr total, total time +3 cycles.
REQ-039 channel_en low after WRITE beat 2 of 4: SHALL enter HOLD with HTrans=IDLE; on re-enable SHALL resume NONSEQ for the remaining 2 beats.
REQ-040 With DMAC_ERR_ABORT_EN, HResp=01 on READ beat 3: SHALL enter ERROR, irq_err=1, no further fifo_wr; channel_en=0 SHALL return to IDLE.
REQ-041 rst pulsed mid-WRITE, then cfg_total=0 with enable: reset SHALL zero all outputs; the zero-length transfer SHALL pulse irq_done once with no beats.
